// File: rtl/mem_slave_responder.sv
// -----------------------------------------------------------------------------
// mem_slave_responder
//
// Memory-backed responder for one crossbar slave port. A one-cycle req is
// accepted in IDLE, an ack pulse follows after ACK_DELAY idle cycles, and a
// resp pulse carrying rdata follows the ack after RESP_DELAY idle cycles.
// A req arriving while a transaction is in flight is dropped and latches the
// sticky proto_err flag. The storage array is not reset.
//
// Optional feature (compile-time macro): SLAVE_RANDOM_STALL_EN
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1)
//   adds 0..3 extra cycles between ack and resp.
//
// Parameters
//   ADDR_W      width of the word address from the crossbar
//   MEM_DEPTH   number of 32-bit words (power of 2, >= 2)
//   ACK_DELAY   idle cycles between req sample and ack (0..15)
//   RESP_DELAY  idle cycles between ack and resp (0..15)
//
// Ports
//   clk        in   clock, all logic on posedge
//   rst        in   asynchronous active-high reset
//   req        in   one-cycle request pulse
//   cmd        in   0 = read, 1 = write (valid with req)
//   addr       in   word address (valid with req)
//   wdata      in   write data (valid with req when cmd = 1)
//   ack        out  request-accepted pulse
//   resp       out  completion pulse
//   rdata      out  read data, valid with resp, held until the next resp
//   busy       out  high from the cycle after acceptance through resp
//   proto_err  out  sticky, set by a req that could not be accepted
// -----------------------------------------------------------------------------
module mem_slave_responder #(
    parameter int ADDR_W     = 30,
    parameter int MEM_DEPTH  = 256,
    parameter int ACK_DELAY  = 0,
    parameter int RESP_DELAY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              cmd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ack,
    output logic              resp,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              proto_err
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
`ifdef SLAVE_RANDOM_STALL_EN
    // One extra bit so RESP_DELAY + 3 still fits.
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = 4;
`endif
    localparam logic [CNT_W-1:0] ACK_LOAD  = CNT_W'(ACK_DELAY);
    localparam logic [CNT_W-1:0] RESP_LOAD = CNT_W'(RESP_DELAY);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // Elaboration-time guard on the configuration.
    if (ACK_DELAY < 0 || ACK_DELAY > 15 || RESP_DELAY < 0 || RESP_DELAY > 15) begin : g_bad_delay
        $error("mem_slave_responder: ACK_DELAY and RESP_DELAY must be in 0..15");
    end
    if (MEM_DEPTH < 2 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mem_slave_responder: MEM_DEPTH must be a power of 2 and >= 2");
    end

    // Upper address bits only alias onto the array; they are intentionally dropped.
    if (ADDR_W > IDX_W) begin : g_addr_hi
        logic unused_addr_hi_s;
        assign unused_addr_hi_s = ^addr[ADDR_W-1:IDX_W];
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_EXEC = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               cmd_r;
    logic [IDX_W-1:0]   idx_r;
    logic [31:0]        wdata_r;
    logic [31:0]        mem_r [MEM_DEPTH];
    logic [CNT_W-1:0]   exec_load_s;
    logic               do_write_s;

`ifdef SLAVE_RANDOM_STALL_EN
    logic [15:0] lfsr_r;
    logic        lfsr_fb_s;

    assign lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];

    // Free-running stall generator, advances every clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
        end
    end

    assign exec_load_s = RESP_LOAD + {{(CNT_W-2){1'b0}}, lfsr_r[1:0]};
`else
    assign exec_load_s = RESP_LOAD;
`endif

    // The write commits on the same edge that raises resp.
    assign do_write_s = !rst && (state_r == ST_EXEC) && (cnt_r == CNT_ZERO) && cmd_r;

    // Storage array: written on completion of a write, never reset.
    always_ff @(posedge clk) begin
        if (do_write_s) begin
            mem_r[idx_r] <= wdata_r;
        end
    end

    // Handshake FSM with registered ack/resp/rdata/busy/proto_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            cmd_r     <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            wdata_r   <= 32'd0;
            ack       <= 1'b0;
            resp      <= 1'b0;
            rdata     <= 32'd0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            ack  <= 1'b0;
            resp <= 1'b0;
            // Any req outside IDLE (the resp edge included) is dropped.
            if (req && (state_r != ST_IDLE)) begin
                proto_err <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        cmd_r   <= cmd;
                        idx_r   <= addr[IDX_W-1:0];
                        wdata_r <= wdata;
                        cnt_r   <= ACK_LOAD;
                        busy    <= 1'b1;
                        state_r <= ST_ACK;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ST_ACK: begin
                    if (cnt_r == CNT_ZERO) begin
                        ack     <= 1'b1;
                        cnt_r   <= exec_load_s;
                        state_r <= ST_EXEC;
                    end else begin
                        cnt_r   <= cnt_r - CNT_ONE;
                    end
                end
                ST_EXEC: begin
                    if (cnt_r == CNT_ZERO) begin
                        resp    <= 1'b1;
                        rdata   <= cmd_r ? 32'd0 : mem_r[idx_r];
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    cnt_r   <= CNT_ZERO;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
